pcie_req_receiver: RTL and testbench
====================================

PCIE_REQ_RECEIVER -- requirements
Module: pcie_req_receiver

Interface
REQ-001 SHALL have parameter DEPTH, default 8, request FIFO depth in entries (power of two, 2..64).
REQ-002 SHALL have parameter ERR_W, default 8, width of each saturating error counter.
REQ-003 SHALL have port clock, input, 1, sole clock; all flops on rising edge.
REQ-004 SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-005 SHALL have ports RxChipSelect (in, 1), RxWrite (in, 1), RxAddress (in, 64), RxWriteData (in, 32), RxByteEnable (in, 4) and RxWaitRequest (out, 1), forming an Avalon-MM write-only slave for two-beat request writes.
REQ-006 SHALL have ports ConfChipSelect (in, 1), ConfWrite (in, 1), ConfRead (in, 1), ConfAddress (in, 8), ConfWriteData (in, 32), ConfReadData (out, 32) and ConfWaitRequest (out, 1), forming the configuration slave.
REQ-007 SHALL have ports reqValid (out, 1), reqInfo (out, 56) and reqReady (in, 1), forming the reassembled request output stream.

Function
REQ-008 SHALL hold a 64-bit rxBaseAddr, with bits [63:32] written at Conf address 0x10 and bits [31:0] at 0x14, both readable.
REQ-009 SHALL return, on a Conf read at 0x18, {16'd0, orphanErr[7:0], fifoCount[7:0]}; at 0x1C, {24'd0, dupErr[7:0]}; at any other address, 0. Counters narrower than 8 bits SHALL be zero-extended and wider ones truncated.
REQ-010 SHALL register ConfReadData one cycle after ConfChipSelect&ConfRead, and ConfWaitRequest SHALL be tied to 0.
REQ-011 SHALL define an accepted beat as RxChipSelect&RxWrite&~RxWaitRequest.
REQ-012 SHALL treat beats with RxAddress equal to rxBaseAddr as HI and beats equal to rxBaseAddr+4 as LO; all other addresses are accepted without wait and have no effect.
REQ-013 SHALL implement a two-state FSM: IDLE and HAVE_HI.
REQ-014 In IDLE, a HI beat SHALL latch RxWriteData[23:0] as hiWord and transition to HAVE_HI.
REQ-015 In IDLE, a LO beat SHALL be dropped and increment orphanErr.
REQ-016 In HAVE_HI, a LO beat SHALL push {hiWord, RxWriteData} into the FIFO and transition to IDLE.
REQ-017 In HAVE_HI, a HI beat SHALL overwrite hiWord, stay in HAVE_HI, and increment dupErr.
REQ-018 A HI or LO beat with RxByteEnable != 4'hf SHALL be dropped, leave the FSM unchanged, and increment orphanErr.
REQ-019 RxWaitRequest SHALL equal FIFO full & state==HAVE_HI & the current beat decoding as LO; it SHALL be 0 for all other beats, and it is combinational.
REQ-020 The FIFO SHALL be first-word-fall-through: a pushed entry SHALL appear on reqValid/reqInfo the cycle after the push.
REQ-021 A pop SHALL occur on reqValid&reqReady; reqInfo SHALL hold stable while reqValid&~reqReady.
REQ-022 A simultaneous push and pop SHALL be legal and leave fifoCount unchanged, including at count==DEPTH-1 and count==1.
REQ-023 Error counters SHALL saturate at all-ones, and SHALL clear on a Conf write to 0x18 (orphanErr) or 0x1C (dupErr). A same-cycle increment and clear SHALL result in 0.
REQ-024 Writes to rxBaseAddr while in HAVE_HI SHALL force the FSM to IDLE and discard hiWord.

Reset
REQ-025 On reset, the module SHALL drive: FSM=IDLE, rxBaseAddr=0, hiWord=0, FIFO empty, reqValid=0, reqInfo=0, ConfReadData=0, error counters=0, and RxWaitRequest=0.
REQ-026 Reset asserted mid-request SHALL discard both the partial request and the FIFO contents, with no spurious reqValid after release.

Configuration
REQ-027 The macro PCIE_REQ_RX_HDR_CHECK_EN SHALL control header checking.
REQ-028 When PCIE_REQ_RX_HDR_CHECK_EN is defined, a HI beat with RxWriteData[31:24]!=0 SHALL be dropped, leave the FSM unchanged, and increment orphanErr.
REQ-029 When PCIE_REQ_RX_HDR_CHECK_EN is undefined, RxWriteData[31:24] SHALL be ignored and no check logic SHALL be generated.

Structure
REQ-030 The shared package pcie_dma_pkg SHALL hold the Conf register offsets (0x10, 0x14, 0x18, 0x1C), the 56-bit request width constant, and the FSM state encoding.
REQ-031 A single sub-module pcie_req_fifo SHALL implement the parameterized FWFT register FIFO, with push, pop, full, empty and count ports.

Verification
REQ-032 Base=0x0000_0001_0000_1000; HI 0x00ABCDEF at 0x1_0000_1000, then LO 0x12345678 at 0x1_0000_1004 -> next cycle reqValid=1, reqInfo=0xABCDEF12345678.
REQ-033 LO at base+4 in IDLE -> no push, orphanErr=1; then HI twice then LO -> dupErr=1, one push carrying the second HI data.
REQ-034 reqReady=0, 8 complete requests, then HI plus LO -> RxWaitRequest=1 on the LO beat; one pop -> LO accepted next cycle, with 8 entries in order.
REQ-035 reqReady=1 with back-to-back requests -> simultaneous push and pop, fifoCount constant, and no loss.
REQ-036 Reset pulse in HAVE_HI -> LO after release counts orphanErr=1 and reqValid stays 0. With PCIE_REQ_RX_HDR_CHECK_EN defined, HI 0x01000000 -> dropped, orphanErr=1.

Source files
------------

// File: rtl/pcie_dma_pkg.sv
// pcie_dma_pkg: shared Conf register offsets, request width and receiver FSM encoding
package pcie_dma_pkg;
    localparam logic [7:0] CONF_BASE_HI = 8'h10;
    localparam logic [7:0] CONF_BASE_LO = 8'h14;
    localparam logic [7:0] CONF_ORPHAN  = 8'h18;
    localparam logic [7:0] CONF_DUP     = 8'h1C;
    localparam int REQ_W = 56;
    typedef enum logic {ST_IDLE = 1'b0, ST_HAVE_HI = 1'b1} rx_state_t;
endpackage

// File: rtl/pcie_req_receiver_if.sv
// pcie_req_receiver_if: Rx write slave, Conf slave and reassembled request stream bundle
interface pcie_req_receiver_if;
    import pcie_dma_pkg::*;
    logic             RxChipSelect;
    logic             RxWrite;
    logic [63:0]      RxAddress;
    logic [31:0]      RxWriteData;
    logic [3:0]       RxByteEnable;
    logic             RxWaitRequest;
    logic             ConfChipSelect;
    logic             ConfWrite;
    logic             ConfRead;
    logic [7:0]       ConfAddress;
    logic [31:0]      ConfWriteData;
    logic [31:0]      ConfReadData;
    logic             ConfWaitRequest;
    logic             reqValid;
    logic [REQ_W-1:0] reqInfo;
    logic             reqReady;
    modport slave (
        input  RxChipSelect, RxWrite, RxAddress, RxWriteData, RxByteEnable,
        output RxWaitRequest,
        input  ConfChipSelect, ConfWrite, ConfRead, ConfAddress, ConfWriteData,
        output ConfReadData, ConfWaitRequest,
        output reqValid, reqInfo,
        input  reqReady
    );
    modport master (
        output RxChipSelect, RxWrite, RxAddress, RxWriteData, RxByteEnable,
        input  RxWaitRequest,
        output ConfChipSelect, ConfWrite, ConfRead, ConfAddress, ConfWriteData,
        input  ConfReadData, ConfWaitRequest,
        input  reqValid, reqInfo,
        output reqReady
    );
endinterface

// File: rtl/pcie_req_fifo.sv
// pcie_req_fifo: first-word-fall-through register FIFO; head entry is visible whenever non-empty
module pcie_req_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 56
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   i_push,
    input  logic [W-1:0]           i_data,
    input  logic                   i_pop,
    output logic [W-1:0]           o_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;
    assign o_full  = r_count == (AW+1)'(DEPTH);
    assign o_empty = r_count == '0;
    assign o_count = r_count;
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_data  = o_empty ? '0 : r_mem[r_rd];
    // storage array; contents are don't-care while not counted, so no reset needed
    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wr] <= i_data;
    end
    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            r_wr    <= r_wr + AW'(w_push);
            r_rd    <= r_rd + AW'(w_pop);
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end
endmodule

// File: rtl/pcie_req_receiver.sv
// pcie_req_receiver: reassembles two-beat HI/LO request writes into 56-bit FIFO entries.
// Optional header check on HI beats is enabled by defining PCIE_REQ_RX_HDR_CHECK_EN.
module pcie_req_receiver
    import pcie_dma_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int ERR_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    pcie_req_receiver_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    rx_state_t        r_state;
    rx_state_t        w_next;
    logic [63:0]      r_base;
    logic [23:0]      r_hi_word;
    logic [ERR_W-1:0] r_orphan;
    logic [ERR_W-1:0] r_dup;
    logic [31:0]      r_rdata;
    logic             w_beat, w_is_hi, w_is_lo, w_be_ok, w_hi_ok, w_hi_good, w_lo_good;
    logic             w_push, w_hi_load, w_orphan_inc, w_dup_inc;
    logic             w_conf_wr, w_base_wr, w_full, w_empty;
    logic [CW-1:0]    w_count;
    logic [7:0]       w_orphan8, w_dup8, w_count8;
    logic [31:0]      w_rd_mux;

    assign w_is_hi   = bus.RxAddress == r_base;
    assign w_is_lo   = bus.RxAddress == r_base + 64'd4;
    assign bus.RxWaitRequest = bus.RxChipSelect & bus.RxWrite & w_full & (r_state == ST_HAVE_HI) & w_is_lo;
    assign w_beat    = bus.RxChipSelect & bus.RxWrite & ~bus.RxWaitRequest;
    assign w_be_ok   = bus.RxByteEnable == 4'hf;
`ifdef PCIE_REQ_RX_HDR_CHECK_EN
    assign w_hi_ok   = w_be_ok & (bus.RxWriteData[31:24] == 8'd0);
`else
    assign w_hi_ok   = w_be_ok;
`endif
    assign w_hi_good = w_beat & w_is_hi & w_hi_ok;
    assign w_lo_good = w_beat & w_is_lo & w_be_ok;
    assign w_conf_wr = bus.ConfChipSelect & bus.ConfWrite;
    assign w_base_wr = w_conf_wr & ((bus.ConfAddress == CONF_BASE_HI) | (bus.ConfAddress == CONF_BASE_LO));
    assign bus.ConfWaitRequest = 1'b0;
    assign bus.ConfReadData    = r_rdata;
    assign bus.reqValid        = ~w_empty;

    // request state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // next state and per-beat actions; a base rewrite abandons any half-built request
    always_comb begin
        w_next       = r_state;
        w_push       = 1'b0;
        w_hi_load    = 1'b0;
        w_dup_inc    = 1'b0;
        w_orphan_inc = w_beat & ((w_is_hi & ~w_hi_ok) | (w_is_lo & ~w_be_ok));
        case (r_state)
            ST_IDLE: begin
                w_hi_load = w_hi_good;
                if (w_hi_good) w_next = ST_HAVE_HI;
                if (w_lo_good) w_orphan_inc = 1'b1;
            end
            ST_HAVE_HI: begin
                w_hi_load = w_hi_good;
                w_dup_inc = w_hi_good;
                w_push    = w_lo_good;
                if (w_lo_good) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
        if (w_base_wr) w_next = ST_IDLE;
    end

    // latched header bits of the pending request
    always_ff @(posedge clock or posedge reset) begin
        if (reset)          r_hi_word <= '0;
        else if (w_base_wr) r_hi_word <= '0;
        else if (w_hi_load) r_hi_word <= bus.RxWriteData[23:0];
    end

    // 64-bit decode base, written as two 32-bit halves
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_base <= '0;
        else if (w_conf_wr && bus.ConfAddress == CONF_BASE_HI) r_base[63:32] <= bus.ConfWriteData;
        else if (w_conf_wr && bus.ConfAddress == CONF_BASE_LO) r_base[31:0]  <= bus.ConfWriteData;
    end

    // orphan counter: saturating, clear wins over a same-cycle increment
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_orphan <= '0;
        else if (w_conf_wr && bus.ConfAddress == CONF_ORPHAN) r_orphan <= '0;
        else if (w_orphan_inc && !(&r_orphan)) r_orphan <= r_orphan + 1'b1;
    end

    // duplicate-HI counter: saturating, clear wins over a same-cycle increment
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_dup <= '0;
        else if (w_conf_wr && bus.ConfAddress == CONF_DUP) r_dup <= '0;
        else if (w_dup_inc && !(&r_dup)) r_dup <= r_dup + 1'b1;
    end

    // status fields are reported as exactly 8 bits regardless of counter width
    if (ERR_W >= 8) begin : g_err_trunc
        assign w_orphan8 = r_orphan[7:0];
        assign w_dup8    = r_dup[7:0];
    end else begin : g_err_ext
        assign w_orphan8 = {{(8-ERR_W){1'b0}}, r_orphan};
        assign w_dup8    = {{(8-ERR_W){1'b0}}, r_dup};
    end
    assign w_count8 = {{(8-CW){1'b0}}, w_count};

    assign w_rd_mux = (bus.ConfAddress == CONF_BASE_HI) ? r_base[63:32] :
                      (bus.ConfAddress == CONF_BASE_LO) ? r_base[31:0] :
                      (bus.ConfAddress == CONF_ORPHAN)  ? {16'd0, w_orphan8, w_count8} :
                      (bus.ConfAddress == CONF_DUP)     ? {24'd0, w_dup8} : 32'd0;

    // registered Conf read data, held between reads
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_rdata <= '0;
        else if (bus.ConfChipSelect && bus.ConfRead) r_rdata <= w_rd_mux;
    end

    pcie_req_fifo #(.DEPTH(DEPTH), .W(REQ_W)) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  ({r_hi_word, bus.RxWriteData}),
        .i_pop   (bus.reqValid & bus.reqReady),
        .o_data  (bus.reqInfo),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );
endmodule

// File: tb/tb_pcie_req_receiver.sv
// tb_pcie_req_receiver: randomized scenarios checked against a request-level reference model
module tb_pcie_req_receiver;
    import pcie_dma_pkg::*;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int fails  = 0;
    logic [63:0] m_base;
    bit          m_pending;
    logic [23:0] m_hi;
    logic [55:0] m_q[$];
    int          m_orphan, m_dup;

    pcie_req_receiver_if bus();
    pcie_req_receiver #(.DEPTH(8), .ERR_W(8)) dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    function automatic void m_reset();
        m_base = '0; m_pending = 0; m_hi = '0; m_q.delete(); m_orphan = 0; m_dup = 0;
    endfunction

    function automatic void m_beat(input logic [63:0] a, input logic [31:0] d, input logic [3:0] be);
        bit hdr_bad;
        hdr_bad = 0;
`ifdef PCIE_REQ_RX_HDR_CHECK_EN
        hdr_bad = d[31:24] != 8'd0;
`endif
        if (a == m_base) begin
            if (be != 4'hf || hdr_bad) m_orphan = (m_orphan == 255) ? 255 : m_orphan + 1;
            else begin
                if (m_pending) m_dup = (m_dup == 255) ? 255 : m_dup + 1;
                m_pending = 1; m_hi = d[23:0];
            end
        end else if (a == m_base + 64'd4) begin
            if (be == 4'hf && m_pending) begin
                m_q.push_back({m_hi, d}); m_pending = 0;
            end else m_orphan = (m_orphan == 255) ? 255 : m_orphan + 1;
        end
    endfunction

    function automatic void m_conf_write(input logic [7:0] a, input logic [31:0] d);
        if (a == CONF_BASE_HI) begin m_base[63:32] = d; m_pending = 0; m_hi = '0; end
        if (a == CONF_BASE_LO) begin m_base[31:0]  = d; m_pending = 0; m_hi = '0; end
        if (a == CONF_ORPHAN) m_orphan = 0;
        if (a == CONF_DUP)    m_dup = 0;
    endfunction

    task automatic rx_write(input logic [63:0] a, input logic [31:0] d, input logic [3:0] be = 4'hf);
        bus.RxChipSelect = 1; bus.RxWrite = 1; bus.RxAddress = a; bus.RxWriteData = d; bus.RxByteEnable = be;
        m_beat(a, d, be);
        @(posedge clock); #1;
        bus.RxChipSelect = 0; bus.RxWrite = 0;
    endtask

    task automatic conf_write(input logic [7:0] a, input logic [31:0] d);
        bus.ConfChipSelect = 1; bus.ConfWrite = 1; bus.ConfAddress = a; bus.ConfWriteData = d;
        m_conf_write(a, d);
        @(posedge clock); #1;
        bus.ConfChipSelect = 0; bus.ConfWrite = 0;
    endtask

    task automatic conf_read(input logic [7:0] a, output logic [31:0] d);
        bus.ConfChipSelect = 1; bus.ConfRead = 1; bus.ConfAddress = a;
        @(posedge clock); #1;
        bus.ConfChipSelect = 0; bus.ConfRead = 0;
        d = bus.ConfReadData;
    endtask

    task automatic pop_one();
        bus.reqReady = 1;
        @(posedge clock); #1;
        bus.reqReady = 0;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        repeat (2) @(posedge clock);
        #1;
        checks++; if (bus.reqValid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", bus.reqValid); end
        checks++; if (bus.reqInfo !== 56'd0) begin fails++; $display("FAIL reset_info: got %h expected 0", bus.reqInfo); end
        checks++; if (bus.ConfReadData !== 32'd0) begin fails++; $display("FAIL reset_rdata: got %h expected 0", bus.ConfReadData); end
        checks++; if (bus.RxWaitRequest !== 1'b0) begin fails++; $display("FAIL reset_wait: got %b expected 0", bus.RxWaitRequest); end
        checks++; if (bus.ConfWaitRequest !== 1'b0) begin fails++; $display("FAIL reset_confwait: got %b expected 0", bus.ConfWaitRequest); end
        reset = 0;
        conf_read(CONF_ORPHAN, rd);
        checks++; if (rd !== 32'd0) begin fails++; $display("FAIL reset_status: got %h expected 0", rd); end
        conf_read(CONF_BASE_LO, rd);
        checks++; if (rd !== m_base[31:0]) begin fails++; $display("FAIL reset_base: got %h expected %h", rd, m_base[31:0]); end
    endtask

    task automatic test_basic();
        logic [31:0] rd;
        logic [55:0] exp;
        conf_write(CONF_BASE_HI, 32'h0000_0001);
        conf_write(CONF_BASE_LO, 32'h0000_1000);
        conf_read(CONF_BASE_HI, rd);
        checks++; if (rd !== m_base[63:32]) begin fails++; $display("FAIL base_hi_rd: got %h expected %h", rd, m_base[63:32]); end
        conf_read(CONF_BASE_LO, rd);
        checks++; if (rd !== m_base[31:0]) begin fails++; $display("FAIL base_lo_rd: got %h expected %h", rd, m_base[31:0]); end
        conf_read(8'h20, rd);
        checks++; if (rd !== 32'd0) begin fails++; $display("FAIL unmapped_rd: got %h expected 0", rd); end
        rx_write(64'h1_0000_1000, 32'h00AB_CDEF);
        checks++; if (bus.reqValid !== 1'b0) begin fails++; $display("FAIL basic_early_valid: got %b expected 0", bus.reqValid); end
        rx_write(64'h1_0000_1004, 32'h1234_5678);
        checks++; if (bus.reqValid !== 1'b1) begin fails++; $display("FAIL basic_valid: got %b expected 1", bus.reqValid); end
        checks++; if (bus.reqInfo !== 56'hAB_CDEF_1234_5678) begin fails++; $display("FAIL basic_info: got %h expected abcdef12345678", bus.reqInfo); end
        conf_read(CONF_ORPHAN, rd);
        checks++; if (rd[7:0] !== 8'(m_q.size())) begin fails++; $display("FAIL basic_count: got %0d expected %0d", rd[7:0], m_q.size()); end
        exp = m_q.pop_front();
        checks++; if (bus.reqInfo !== exp) begin fails++; $display("FAIL basic_model: got %h expected %h", bus.reqInfo, exp); end
        pop_one();
        checks++; if (bus.reqValid !== 1'b0) begin fails++; $display("FAIL basic_popped: got %b expected 0", bus.reqValid); end
        rx_write(m_base + 64'd8, $urandom);
        rx_write(m_base - 64'd4, $urandom);
        conf_read(CONF_ORPHAN, rd);
        checks++; if (rd !== {16'd0, 8'(m_orphan), 8'(m_q.size())}) begin fails++; $display("FAIL other_addr: got %h expected %h", rd, {16'd0, 8'(m_orphan), 8'(m_q.size())}); end
    endtask

    task automatic test_errors();
        logic [31:0] rd, h1, h2, lo;
        logic [55:0] exp;
        rx_write(m_base + 64'd4, $urandom);
        conf_read(CONF_ORPHAN, rd);
        checks++; if (rd[15:8] !== 8'(m_orphan)) begin fails++; $display("FAIL orphan_lo: got %0d expected %0d", rd[15:8], m_orphan); end
        h1 = $urandom & 32'h00FF_FFFF; h2 = $urandom & 32'h00FF_FFFF; lo = $urandom;
        rx_write(m_base, h1);
        rx_write(m_base, h2);
        rx_write(m_base + 64'd4, lo);
        conf_read(CONF_DUP, rd);
        checks++; if (rd !== 32'(m_dup)) begin fails++; $display("FAIL dup_count: got %h expected %h", rd, 32'(m_dup)); end
        exp = m_q.pop_front();
        checks++; if (bus.reqValid !== 1'b1 || bus.reqInfo !== exp) begin fails++; $display("FAIL dup_info: got %b/%h expected 1/%h", bus.reqValid, bus.reqInfo, exp); end
        pop_one();
        rx_write(m_base, $urandom & 32'h00FF_FFFF, 4'h7);
        rx_write(m_base, $urandom & 32'h00FF_FFFF);
        rx_write(m_base + 64'd4, $urandom, 4'hE);
        rx_write(m_base + 64'd4, $urandom);
        conf_read(CONF_ORPHAN, rd);
        checks++; if (rd[15:8] !== 8'(m_orphan)) begin fails++; $display("FAIL orphan_be: got %0d expected %0d", rd[15:8], m_orphan); end
        exp = m_q.pop_front();
        checks++; if (bus.reqValid !== 1'b1 || bus.reqInfo !== exp) begin fails++; $display("FAIL be_keep_state: got %b/%h expected 1/%h", bus.reqValid, bus.reqInfo, exp); end
        pop_one();
        rx_write(m_base, $urandom & 32'h00FF_FFFF);
        conf_write(CONF_BASE_LO, m_base[31:0]);
        rx_write(m_base + 64'd4, $urandom);
        conf_read(CONF_ORPHAN, rd);
        checks++; if (rd !== {16'd0, 8'(m_orphan), 8'(m_q.size())}) begin fails++; $display("FAIL base_wr_abort: got %h expected %h", rd, {16'd0, 8'(m_orphan), 8'(m_q.size())}); end
        for (int i = 0; i < 300; i++) rx_write(m_base + 64'd4, $urandom);
        conf_read(CONF_ORPHAN, rd);
        checks++; if (rd[15:8] !== 8'(m_orphan)) begin fails++; $display("FAIL orphan_sat: got %0d expected %0d", rd[15:8], m_orphan); end
        bus.RxChipSelect = 1; bus.RxWrite = 1; bus.RxAddress = m_base + 64'd4; bus.RxWriteData = $urandom; bus.RxByteEnable = 4'hf;
        bus.ConfChipSelect = 1; bus.ConfWrite = 1; bus.ConfAddress = CONF_ORPHAN; bus.ConfWriteData = 32'd0;
        m_beat(bus.RxAddress, bus.RxWriteData, 4'hf);
        m_conf_write(CONF_ORPHAN, 32'd0);
        @(posedge clock); #1;
        bus.RxChipSelect = 0; bus.RxWrite = 0; bus.ConfChipSelect = 0; bus.ConfWrite = 0;
        conf_read(CONF_ORPHAN, rd);
        checks++; if (rd[15:8] !== 8'(m_orphan)) begin fails++; $display("FAIL inc_clear: got %0d expected %0d", rd[15:8], m_orphan); end
        conf_write(CONF_DUP, 32'd0);
        conf_read(CONF_DUP, rd);
        checks++; if (rd !== 32'(m_dup)) begin fails++; $display("FAIL dup_clear: got %h expected %h", rd, 32'(m_dup)); end
    endtask

    task automatic test_full();
        logic [31:0] rd, lo;
        logic [55:0] exp;
        bus.reqReady = 0;
        for (int i = 0; i < 8; i++) begin
            rx_write(m_base, $urandom & 32'h00FF_FFFF);
            rx_write(m_base + 64'd4, $urandom);
        end
        conf_read(CONF_ORPHAN, rd);
        checks++; if (rd[7:0] !== 8'(m_q.size())) begin fails++; $display("FAIL full_count: got %0d expected %0d", rd[7:0], m_q.size()); end
        rx_write(m_base, $urandom & 32'h00FF_FFFF);
        lo = $urandom;
        bus.RxChipSelect = 1; bus.RxWrite = 1; bus.RxAddress = m_base + 64'd4; bus.RxWriteData = lo; bus.RxByteEnable = 4'hf;
        #1;
        checks++; if (bus.RxWaitRequest !== 1'b1) begin fails++; $display("FAIL full_wait: got %b expected 1", bus.RxWaitRequest); end
        @(posedge clock); #1;
        checks++; if (bus.RxWaitRequest !== 1'b1 || bus.reqInfo !== m_q[0]) begin fails++; $display("FAIL full_hold: got %b/%h expected 1/%h", bus.RxWaitRequest, bus.reqInfo, m_q[0]); end
        bus.reqReady = 1;
        @(negedge clock);
        exp = m_q.pop_front();
        checks++; if (bus.reqInfo !== exp) begin fails++; $display("FAIL full_pop_info: got %h expected %h", bus.reqInfo, exp); end
        @(posedge clock); #1;
        bus.reqReady = 0;
        checks++; if (bus.RxWaitRequest !== 1'b0) begin fails++; $display("FAIL full_release: got %b expected 0", bus.RxWaitRequest); end
        m_beat(m_base + 64'd4, lo, 4'hf);
        @(posedge clock); #1;
        bus.RxChipSelect = 0; bus.RxWrite = 0;
        conf_read(CONF_ORPHAN, rd);
        checks++; if (rd[7:0] !== 8'(m_q.size())) begin fails++; $display("FAIL full_refill: got %0d expected %0d", rd[7:0], m_q.size()); end
        for (int i = 0; i < 16 && m_q.size() > 0; i++) begin
            exp = m_q.pop_front();
            checks++; if (bus.reqValid !== 1'b1 || bus.reqInfo !== exp) begin fails++; $display("FAIL full_drain%0d: got %b/%h expected 1/%h", i, bus.reqValid, bus.reqInfo, exp); end
            pop_one();
        end
        checks++; if (bus.reqValid !== 1'b0) begin fails++; $display("FAIL full_empty: got %b expected 0", bus.reqValid); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        logic [55:0] exp;
        int ks[3];
        ks[0] = 1; ks[1] = 7; ks[2] = $urandom_range(2, 6);
        for (int r = 0; r < 3; r++) begin
            bus.reqReady = 0;
            for (int i = 0; i < ks[r]; i++) begin
                rx_write(m_base, $urandom & 32'h00FF_FFFF);
                rx_write(m_base + 64'd4, $urandom);
            end
            for (int j = 0; j < 12; j++) begin
                rx_write(m_base, $urandom & 32'h00FF_FFFF);
                exp = m_q.pop_front();
                bus.RxChipSelect = 1; bus.RxWrite = 1; bus.RxAddress = m_base + 64'd4; bus.RxWriteData = $urandom; bus.RxByteEnable = 4'hf;
                bus.reqReady = 1;
                m_beat(bus.RxAddress, bus.RxWriteData, 4'hf);
                @(negedge clock);
                checks++; if (bus.reqValid !== 1'b1 || bus.reqInfo !== exp || bus.RxWaitRequest !== 1'b0) begin fails++; $display("FAIL b2b_k%0d_%0d: got %b/%h expected 1/%h", ks[r], j, bus.reqValid, bus.reqInfo, exp); end
                @(posedge clock); #1;
                bus.RxChipSelect = 0; bus.RxWrite = 0; bus.reqReady = 0;
            end
            conf_read(CONF_ORPHAN, rd);
            checks++; if (rd[7:0] !== 8'(ks[r])) begin fails++; $display("FAIL b2b_count_k%0d: got %0d expected %0d", ks[r], rd[7:0], ks[r]); end
            for (int i = 0; i < 16 && m_q.size() > 0; i++) begin
                exp = m_q.pop_front();
                checks++; if (bus.reqValid !== 1'b1 || bus.reqInfo !== exp) begin fails++; $display("FAIL b2b_drain%0d: got %b/%h expected 1/%h", i, bus.reqValid, bus.reqInfo, exp); end
                pop_one();
            end
            checks++; if (bus.reqValid !== 1'b0) begin fails++; $display("FAIL b2b_empty: got %b expected 0", bus.reqValid); end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        conf_write(CONF_BASE_HI, 32'h0000_0002);
        conf_write(CONF_BASE_LO, 32'h0000_0040);
        for (int i = 0; i < 2; i++) begin
            rx_write(m_base, $urandom & 32'h00FF_FFFF);
            rx_write(m_base + 64'd4, $urandom);
        end
        rx_write(m_base, $urandom & 32'h00FF_FFFF);
        #3 reset = 1;
        #1;
        checks++; if (bus.reqValid !== 1'b0) begin fails++; $display("FAIL async_reset_valid: got %b expected 0", bus.reqValid); end
        m_reset();
        @(posedge clock); #1 reset = 0;
        rx_write(64'h4, $urandom);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checks++; if (bus.reqValid !== 1'b0) begin fails++; $display("FAIL post_reset_valid%0d: got %b expected 0", i, bus.reqValid); end
        end
        conf_read(CONF_ORPHAN, rd);
        checks++; if (rd !== {16'd0, 8'(m_orphan), 8'(m_q.size())}) begin fails++; $display("FAIL post_reset_orphan: got %h expected %h", rd, {16'd0, 8'(m_orphan), 8'(m_q.size())}); end
        conf_write(CONF_ORPHAN, 32'd0);
        rx_write(64'h0, 32'h0100_0000);
        conf_read(CONF_ORPHAN, rd);
        checks++; if (rd[15:8] !== 8'(m_orphan)) begin fails++; $display("FAIL hdr_hi: got %0d expected %0d", rd[15:8], m_orphan); end
        rx_write(64'h4, 32'h0000_0055);
        conf_read(CONF_ORPHAN, rd);
        checks++; if (rd !== {16'd0, 8'(m_orphan), 8'(m_q.size())}) begin fails++; $display("FAIL hdr_lo: got %h expected %h", rd, {16'd0, 8'(m_orphan), 8'(m_q.size())}); end
        checks++; if (bus.reqValid !== (m_q.size() != 0) || (m_q.size() != 0 && bus.reqInfo !== m_q[0])) begin fails++; $display("FAIL hdr_out: got %b/%h expected %b", bus.reqValid, bus.reqInfo, m_q.size() != 0); end
    endtask

    initial begin
        bus.RxChipSelect = 0; bus.RxWrite = 0; bus.RxAddress = '0; bus.RxWriteData = '0; bus.RxByteEnable = '0;
        bus.ConfChipSelect = 0; bus.ConfWrite = 0; bus.ConfRead = 0; bus.ConfAddress = '0; bus.ConfWriteData = '0;
        bus.reqReady = 0;
        m_reset();
        test_reset();
        test_basic();
        test_errors();
        test_full();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
